// File: rtl/score_board_reader.sv
// Scans the score RAM on request and publishes the highest score and its owner.
// Optional macro SCORE_BOARD_CYCLE_EN adds a rotating per-slot display.
module score_board_reader #(
  parameter int NUM_USERS = 6,
  parameter int SCORE_W   = 8,
  parameter int ADDR_W    = 3,
  parameter int RAM_LAT   = 1,
  parameter int DWELL_CYC = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_req,
  input  logic               game_active,
  output logic               ram_rd_en,
  output logic [ADDR_W-1:0]  ram_rd_addr,
  input  logic [SCORE_W-1:0] ram_rd_data,
  output logic               scan_busy,
  output logic               scan_done,
  output logic               best_valid,
  output logic [SCORE_W-1:0] best_score,
  output logic [ADDR_W-1:0]  best_user,
  output logic               scan_empty,
  output logic [ADDR_W-1:0]  disp_user,
  output logic [SCORE_W-1:0] disp_score
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NUM_USERS - 1);

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  rd_cnt_next;
  logic [ADDR_W-1:0]  cap_cnt;
  logic [ADDR_W-1:0]  cap_cnt_next;
  logic [RAM_LAT-1:0] valid_pipe;
  logic               capture;
  logic [SCORE_W-1:0] acc_score;
  logic [SCORE_W-1:0] acc_score_next;
  logic [ADDR_W-1:0]  acc_user;
  logic [ADDR_W-1:0]  acc_user_next;
  logic               finish;

  assign capture = valid_pipe[RAM_LAT-1] && ((state == READ) || (state == DRAIN));

  // Next-state, read counter and running-max accumulator.
  always_comb begin
    state_next     = state;
    rd_cnt_next    = ram_rd_addr;
    cap_cnt_next   = cap_cnt;
    acc_score_next = acc_score;
    acc_user_next  = acc_user;
    finish         = 1'b0;
    if (capture) begin
      cap_cnt_next = cap_cnt + 1'b1;
      // Strict compare keeps the lower slot on a tie.
      if (ram_rd_data > acc_score) begin
        acc_score_next = ram_rd_data;
        acc_user_next  = cap_cnt;
      end else begin
        acc_score_next = acc_score;
      end
    end else begin
      cap_cnt_next = cap_cnt;
    end
    case (state)
      IDLE: begin
        if (scan_req && !game_active) begin
          state_next     = READ;
          rd_cnt_next    = '0;
          cap_cnt_next   = '0;
          acc_score_next = '0;
          acc_user_next  = '0;
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        if (ram_rd_addr == LAST_SLOT) begin
          state_next = DRAIN;
        end else begin
          rd_cnt_next = ram_rd_addr + 1'b1;
        end
      end
      DRAIN: begin
        // Results are latched on the edge entering DONE so scan_done is seen in DONE.
        if (capture && (cap_cnt == LAST_SLOT)) begin
          state_next = DONE;
          finish     = 1'b1;
        end else begin
          state_next = DRAIN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state, read strobe, capture tracking and published results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      cap_cnt     <= '0;
      valid_pipe  <= '0;
      acc_score   <= '0;
      acc_user    <= '0;
      scan_busy   <= 1'b0;
      scan_done   <= 1'b0;
      best_valid  <= 1'b0;
      best_score  <= '0;
      best_user   <= '0;
      scan_empty  <= 1'b0;
    end else begin
      state         <= state_next;
      ram_rd_en     <= (state_next == READ);
      ram_rd_addr   <= rd_cnt_next;
      cap_cnt       <= cap_cnt_next;
      valid_pipe[0] <= ram_rd_en;
      for (int i = 1; i < RAM_LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
      end
      acc_score     <= acc_score_next;
      acc_user      <= acc_user_next;
      scan_busy     <= (state_next != IDLE);
      scan_done     <= finish;
      if (finish) begin
        best_valid <= 1'b1;
        best_score <= acc_score_next;
        best_user  <= acc_user_next;
        scan_empty <= (acc_score_next == '0);
      end else begin
        best_valid <= best_valid;
      end
    end
  end

`ifdef SCORE_BOARD_CYCLE_EN
  localparam int DWELL_W = $clog2(DWELL_CYC + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);

  logic [SCORE_W-1:0] slots [NUM_USERS];
  logic [DWELL_W-1:0] dwell;
  logic [ADDR_W-1:0]  rot_next;

  // Slot to show when the current dwell period expires.
  always_comb begin
    if (disp_user == LAST_SLOT) begin
      rot_next = '0;
    end else begin
      rot_next = disp_user + 1'b1;
    end
  end

  // Per-slot copy of the scanned scores.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_USERS; i++) begin
        slots[i] <= '0;
      end
    end else if (capture) begin
      slots[cap_cnt] <= ram_rd_data;
    end else begin
      slots[0] <= slots[0];
    end
  end

  // Display rotation; restarts at slot 0 on each completed scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell      <= '0;
      disp_user  <= '0;
      disp_score <= '0;
    end else if (finish) begin
      dwell      <= '0;
      disp_user  <= '0;
      // With a single slot, slot 0 is being written on this very edge.
      disp_score <= (cap_cnt == '0) ? ram_rd_data : slots[0];
    end else if (scan_busy || game_active || !best_valid) begin
      dwell <= dwell;
    end else if (dwell == DWELL_LAST) begin
      dwell      <= '0;
      disp_user  <= rot_next;
      disp_score <= slots[rot_next];
    end else begin
      dwell <= dwell + 1'b1;
    end
  end
`else
  // Display mirrors the published best result.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_user  <= '0;
      disp_score <= '0;
    end else if (finish) begin
      disp_user  <= acc_user_next;
      disp_score <= acc_score_next;
    end else begin
      disp_user <= disp_user;
    end
  end
`endif

endmodule

// File: doc/score_board_reader.md
Name: score_board_reader

Overview:
- Read-side counterpart to the score RAM controller, which writes per-user scores into the score RAM.
- On request, scans all user score slots through the RAM read port and finds the highest score and its owner.
- Publishes the result for the hex display path.
- Sits beside the RAM controller in the top level. Idle while a game is in progress.

Parameters:
- NUM_USERS, 6, number of user score slots scanned, at addresses 0..NUM_USERS-1.
- SCORE_W, 8, width of one score word.
- ADDR_W, 3, RAM read address width; must satisfy 2^ADDR_W >= NUM_USERS.
- RAM_LAT, 1, RAM read latency in cycles (must be >= 1).
- DWELL_CYC, 50000000, display dwell per slot in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- scan_req  in  1  one-cycle pulse from a shaped button; requests a scan.
- game_active  in  1  high while a game is running; requests are ignored while high.
- ram_rd_en  out  1  read strobe to the score RAM.
- ram_rd_addr  out  ADDR_W  read address.
- ram_rd_data  in  SCORE_W  read data, valid RAM_LAT cycles after the matching ram_rd_en.
- scan_busy  out  1  high while a scan is in progress.
- scan_done  out  1  one-cycle pulse when results update.
- best_valid  out  1  high once at least one scan has completed.
- best_score  out  SCORE_W  highest score from the last completed scan.
- best_user  out  ADDR_W  slot index owning best_score.
- scan_empty  out  1  all slots read zero in the last completed scan.
- disp_user  out  ADDR_W  user index for the display.
- disp_score  out  SCORE_W  score for the display.

Behaviour:
- Clock is clk; reset rst is synchronous and active-high. All state is registered on the rising edge of clk.
- Reset: all outputs are 0; FSM goes to IDLE; the accumulator and slot array (if present) are cleared.
- Reset mid-scan aborts the scan and produces no scan_done.

FSM states:
- IDLE:
  - scan_req=1 and game_active=0: go to READ; set rd counter=0, capture counter=0; set accumulator to score 0, user 0.
  - scan_req is ignored when game_active=1.
- READ:
  - Drive ram_rd_en=1, ram_rd_addr=rd counter. Increment the counter each cycle.
  - After issuing address NUM_USERS-1, go to DRAIN.
  - Addresses are issued back-to-back, one per cycle: addresses 0..NUM_USERS-1 occupy cycles 1..NUM_USERS after the request.
- DRAIN:
  - ram_rd_en=0. Stay until all NUM_USERS data words have been captured, then go to DONE.
- DONE (one cycle):
  - Copy the accumulator to best_score and best_user; set best_valid=1.
  - Set scan_empty=1 if the accumulated max is 0.
  - Pulse scan_done=1; go to IDLE.

Capture and compare:
- A 1-deep-per-latency valid shift pipe tracks outstanding reads, so capture happens RAM_LAT cycles after each strobe.
- Each captured word is compared with strict greater-than. On a tie, the lower slot index wins.
- All-zero memory gives best_user=0, best_score=0, scan_empty=1.

Timing and request handling:
- scan_busy=1 in READ, DRAIN and DONE.
- scan_req during busy is ignored, with no queuing.
- game_active rising mid-scan does not abort the scan.
- Latency: request sampled at cycle 0 gives scan_done at cycle NUM_USERS+RAM_LAT+1. With defaults this is cycle 8.
- best_* and scan_empty hold their previous values during a scan and change only in DONE.

Display without the optional feature:
- disp_user=best_user, disp_score=best_score, both registered and updated in DONE.

Optional Feature:
- Macro: SCORE_BOARD_CYCLE_EN.
- With SCORE_BOARD_CYCLE_EN defined:
  - Each captured word is also written into an internal NUM_USERS x SCORE_W slot array.
  - After each DONE, the display rotates: disp_user and disp_score show slot 0, then 1, ..., then NUM_USERS-1. Each slot is held for DWELL_CYC cycles, then the sequence wraps to 0.
  - The rotation restarts at slot 0 on every scan_done.
  - The rotation freezes (holds the current slot) while scan_busy=1 or game_active=1.
  - Before the first scan completes, disp_* = 0.
- Without the macro: no slot array and no dwell counter. The display behaves as described in Behaviour.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, ram_rd_en never asserted.
- RAM = {12,40,7,40,3,0}, RAM_LAT=1, scan_req pulse at cycle 0 ->
  - ram_rd_en high cycles 1..6 with addresses 0..5;
  - scan_done pulse at cycle 8;
  - best_score=40, best_user=1 (tie goes to the lower slot), best_valid=1, scan_empty=0.
- RAM all zero, scan_req -> best_score=0, best_user=0, scan_empty=1, best_valid=1.
- scan_req with game_active=1 -> no ram_rd_en, no scan_done.
- Second scan_req during busy -> ignored; exactly one scan_done.
- RAM_LAT=2 -> scan_done at cycle 9 and results correct.
- rst asserted at cycle 4 mid-scan -> scan_busy=0 next cycle, no scan_done, best_valid=0.
- With SCORE_BOARD_CYCLE_EN and DWELL_CYC=4, RAM {5,6,7,8,9,10} -> after scan_done, disp_score steps 5,6,7,8,9,10,5 every 4 cycles; rotation holds while game_active=1.
